// File: rtl/hdr_sched_pkg.sv
// Shared types for the HDR pair scheduler: FSM states, per-pair sideband tag
// and the frame counter width.
package hdr_sched_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
  } sideband_t;

endpackage

// File: rtl/hdr_out_fifo.sv
// Synchronous first-word-fall-through FIFO holding merged pixels plus sof/eol.
// The head entry is always visible on rd_data while empty is low.
module hdr_out_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // One extra pointer bit separates the full and empty cases.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/hdr_pair_sched.sv
// Aligns the short/long exposure streams, issues pixel pairs into the fixed-latency
// HDR merge pipeline and buffers results under credit control. Optional macro
// HDR_SCHED_BYPASS_EN adds cfg_bypass (exposure-0 pass-through at merge latency).
module hdr_pair_sched
  import hdr_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PIPE_LAT   = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef HDR_SCHED_BYPASS_EN
  input  logic                   cfg_bypass,
`endif
  input  logic [DATA_WIDTH-1:0]  s0_data,
  input  logic                   s0_valid,
  input  logic                   s0_sof,
  input  logic                   s0_eol,
  output logic                   s0_ready,
  input  logic [DATA_WIDTH-1:0]  s1_data,
  input  logic                   s1_valid,
  input  logic                   s1_sof,
  input  logic                   s1_eol,
  output logic                   s1_ready,
  output logic [DATA_WIDTH-1:0]  hdr_data_i0,
  output logic [DATA_WIDTH-1:0]  hdr_data_i1,
  input  logic [DATA_WIDTH-1:0]  hdr_result,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  output logic                   m_sof,
  output logic                   m_eol,
  input  logic                   m_ready,
  output logic                   sync_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = DATA_WIDTH + 2;

  state_t                 state_q, state_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0]  hdr0_q, hdr0_d, hdr1_q, hdr1_d;
  logic                   sync_err_q, sync_err_d;
  sideband_t              tag_q [PIPE_LAT+1];
  sideband_t              tag_d [PIPE_LAT+1];
  sideband_t              tag_out;
  logic                   issue, misalign, s0_rdy, s1_rdy, pop;
  logic                   fifo_wr, fifo_empty, fifo_full;
  logic [FW-1:0]          fifo_wdata, fifo_rdata;
  logic [DATA_WIDTH-1:0]  wr_pix;

  // Stage: alignment FSM and issue decision
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    misalign = 1'b0;
    s0_rdy   = 1'b0;
    s1_rdy   = 1'b0;
    case (state_q)
      SYNC: begin
        s0_rdy = s0_valid & ~s0_sof;
        s1_rdy = s1_valid & ~s1_sof;
        if (s0_valid && s1_valid && s0_sof && s1_sof) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (s0_valid && s1_valid && ((s0_sof != s1_sof) || (s0_eol != s1_eol))) begin
          misalign = 1'b1;
          state_d  = SYNC;
        end else if (s0_valid && s1_valid && (credits_q != '0)) begin
          issue  = 1'b1;
          s0_rdy = 1'b1;
          s1_rdy = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    pop       = ~fifo_empty & m_ready;
    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (!issue && pop) begin
      credits_d = credits_q + CW'(1);
    end
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(issue & s0_sof);
    hdr0_d      = issue ? s0_data : hdr0_q;
    hdr1_d      = issue ? s1_data : hdr1_q;
    sync_err_d  = misalign;
    tag_d[0]    = '{valid: issue, sof: issue & s0_sof, eol: issue & s0_eol};
    for (int k = 1; k <= PIPE_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      credits_q   <= CW'(FIFO_DEPTH);
      frame_cnt_q <= '0;
      hdr0_q      <= '0;
      hdr1_q      <= '0;
      sync_err_q  <= 1'b0;
      for (int k = 0; k <= PIPE_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      frame_cnt_q <= frame_cnt_d;
      hdr0_q      <= hdr0_d;
      hdr1_q      <= hdr1_d;
      sync_err_q  <= sync_err_d;
      for (int k = 0; k <= PIPE_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  // Stage: optional exposure-0 bypass line, aligned with the sideband tags
`ifdef HDR_SCHED_BYPASS_EN
  logic [DATA_WIDTH-1:0] byp_data_q [PIPE_LAT+1];
  logic [DATA_WIDTH-1:0] byp_data_d [PIPE_LAT+1];
  logic [PIPE_LAT:0]     byp_sel_q, byp_sel_d;

  always_comb begin
    byp_data_d[0] = s0_data;
    for (int k = 1; k <= PIPE_LAT; k++) begin
      byp_data_d[k] = byp_data_q[k-1];
    end
    byp_sel_d = {byp_sel_q[PIPE_LAT-1:0], issue & cfg_bypass};
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k <= PIPE_LAT; k++) begin
      byp_data_q[k] <= byp_data_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_sel_q <= '0;
    end else begin
      byp_sel_q <= byp_sel_d;
    end
  end

  assign wr_pix = byp_sel_q[PIPE_LAT] ? byp_data_q[PIPE_LAT] : hdr_result;
`else
  assign wr_pix = hdr_result;
`endif

  // Stage: result capture and output FIFO
  assign tag_out    = tag_q[PIPE_LAT];
  assign fifo_wr    = tag_out.valid & ~fifo_full;
  assign fifo_wdata = {wr_pix, tag_out.sof, tag_out.eol};

  hdr_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign m_valid     = ~fifo_empty;
  assign m_data      = fifo_rdata[FW-1:2];
  assign m_sof       = fifo_rdata[1] & ~fifo_empty;
  assign m_eol       = fifo_rdata[0] & ~fifo_empty;
  assign s0_ready    = s0_rdy & ~rst;
  assign s1_ready    = s1_rdy & ~rst;
  assign hdr_data_i0 = hdr0_q;
  assign hdr_data_i1 = hdr1_q;
  assign sync_err    = sync_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hdr_pair_sched.sv
// Bench for hdr_pair_sched: models the external merge pipeline (a + 2*b, PIPE_LAT deep)
// and drives directed vectors plus multi-cycle alignment, backpressure and reset cases.
module tb_hdr_pair_sched;
  localparam int DW = 8;
  localparam int PL = 12;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_valid, s0_sof, s0_eol, s0_ready;
  logic          s1_valid, s1_sof, s1_eol, s1_ready;
  logic [DW-1:0] hdr_data_i0, hdr_data_i1, hdr_result;
  logic [DW-1:0] m_data;
  logic          m_valid, m_sof, m_eol, m_ready;
  logic          sync_err;
  logic [15:0]   frame_cnt;
`ifdef HDR_SCHED_BYPASS_EN
  logic          cfg_bypass;
`endif

  hdr_pair_sched #(.DATA_WIDTH(DW), .PIPE_LAT(PL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
`ifdef HDR_SCHED_BYPASS_EN
    .cfg_bypass(cfg_bypass),
`endif
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_sof(s0_sof), .s0_eol(s0_eol), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_sof(s1_sof), .s1_eol(s1_eol), .s1_ready(s1_ready),
    .hdr_data_i0(hdr_data_i0), .hdr_data_i1(hdr_data_i1), .hdr_result(hdr_result),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_ready(m_ready),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = a + (b << 1);
    return r;
  endfunction

  // External merge datapath: result follows operands by PL clock edges.
  logic [DW-1:0] dp_q [PL];
  always @(posedge clk) begin
    dp_q[0] <= merge(hdr_data_i0, hdr_data_i1);
    for (int k = 1; k < PL; k++) dp_q[k] <= dp_q[k-1];
  end
  assign hdr_result = dp_q[PL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    int            cyc;
  } beat_t;
  beat_t out_q[$];
  beat_t mon_b;
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      mon_b.d = m_data; mon_b.sof = m_sof; mon_b.eol = m_eol; mon_b.cyc = cyc;
      out_q.push_back(mon_b);
    end
  end

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sof;
    logic          eol;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tab [8];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s0_valid = 0; s1_valid = 0; s0_sof = 0; s1_sof = 0; s0_eol = 0; s1_eol = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(2);
    rst = 0;
    tick(1);
  endtask

  // Presents one pair on both streams and returns one cycle after its handshake edge.
  task automatic put_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic sof, input logic eol, output int hc);
    int n;
    s0_data = a; s1_data = b; s0_valid = 1; s1_valid = 1;
    s0_sof = sof; s1_sof = sof; s0_eol = eol; s1_eol = eol;
    n = 0;
    @(negedge clk);
    while (!(s0_ready && s1_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_vec++; n_err++;
      $display("FAIL handshake_timeout: no ready after %0d cycles for pair 0x%0h/0x%0h", n, a, b);
    end
    @(posedge clk); #1;
    hc = cyc;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c;
    c = 0;
    while (out_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc, hc0, hs, k;
    logic stale;

    tab[0] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h50};
    tab[1] = '{8'h11, 8'h21, 1'b0, 1'b0, 8'h53};
    tab[2] = '{8'h22, 8'h05, 1'b0, 1'b0, 8'h2C};
    tab[3] = '{8'h80, 8'h40, 1'b0, 1'b0, 8'h00};
    tab[4] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h01};
    tab[5] = '{8'h03, 8'h70, 1'b0, 1'b0, 8'hE3};
    tab[6] = '{8'h5A, 8'hA5, 1'b0, 1'b0, 8'hA4};
    tab[7] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'h05};

    s0_data = 0; s1_data = 0; m_ready = 1; rst = 1;
`ifdef HDR_SCHED_BYPASS_EN
    cfg_bypass = 0;
`endif
    idle();
    tick(2);
    check("rst_m_valid", m_valid, 0);
    check("rst_s0_ready", s0_ready, 0);
    check("rst_s1_ready", s1_ready, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_hdr_i0", hdr_data_i0, 0);
    check("rst_hdr_i1", hdr_data_i1, 0);
    rst = 0;
    tick(1);

    // Table-driven frame of 8 pairs at full throughput.
    out_q.delete();
    hc0 = 0;
    for (int i = 0; i < 8; i++) begin
      put_pair(tab[i].a, tab[i].b, tab[i].sof, tab[i].eol, hc);
      if (i == 0) begin
        hc0 = hc;
        check("first_hdr_i0", hdr_data_i0, 8'h10);
        check("first_hdr_i1", hdr_data_i1, 8'h20);
      end
    end
    idle();
    wait_beats(8, 60);
    tick(5);
    check("t1_beats", out_q.size(), 8);
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      check($sformatf("t1_data[%0d]", i), out_q[i].d, tab[i].exp);
      check($sformatf("t1_sof[%0d]", i), out_q[i].sof, tab[i].sof);
      check($sformatf("t1_eol[%0d]", i), out_q[i].eol, tab[i].eol);
    end
    if (out_q.size() == 8) begin
      check("t1_latency", out_q[0].cyc - hc0, PL + 1);
      check("t1_throughput", out_q[7].cyc - out_q[0].cyc, 7);
    end
    check("t1_frame_cnt", frame_cnt, 1);

    // s0 starts mid-frame, s1 already at sof.
    do_reset();
    out_q.delete();
    s1_data = 8'h30; s1_valid = 1; s1_sof = 1; s1_eol = 0;
    s0_valid = 1; s0_sof = 0; s0_eol = 0;
    for (int j = 0; j < 3; j++) begin
      s0_data = 8'h91 + 8'(j);
      @(negedge clk);
      check($sformatf("t2_drop_s0[%0d]", j), s0_ready, 1);
      check($sformatf("t2_hold_s1[%0d]", j), s1_ready, 0);
      tick(1);
    end
    s0_data = 8'h31; s0_sof = 1;
    @(negedge clk);
    check("t2_transition_no_hs", {s0_ready, s1_ready}, 2'b00);
    tick(1);
    @(negedge clk);
    check("t2_run_ready", {s0_ready, s1_ready}, 2'b11);
    tick(1);
    check("t2_hdr_i0", hdr_data_i0, 8'h31);
    check("t2_hdr_i1", hdr_data_i1, 8'h30);
    idle();
    wait_beats(1, 40);
    tick(5);
    check("t2_beats", out_q.size(), 1);
    if (out_q.size() >= 1) begin
      check("t2_data", out_q[0].d, 8'h91);
      check("t2_sof", out_q[0].sof, 1);
    end
    check("t2_frame_cnt", frame_cnt, 1);

    // Reset mid-frame with 5 results buffered and 5 pairs in flight.
    do_reset();
    m_ready = 0;
    for (int i = 0; i < 10; i++) put_pair(8'h40 + 8'(i), 8'h01, i == 0, 1'b0, hc);
    idle();
    tick(8);
    check("t5_fifo_loaded", m_valid, 1);
    check("t5_frame_cnt_pre", frame_cnt, 1);
    rst = 1;
    tick(1);
    check("t5_m_valid", m_valid, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    check("t5_hdr_i0", hdr_data_i0, 0);
    rst = 0;
    tick(1);
    stale = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_valid) stale = 1;
      tick(1);
    end
    check("t5_no_stale", stale, 0);

    // Backpressure: continuous stream, downstream stalled.
    out_q.delete();
    k = 0; hs = 0;
    for (int c = 0; c < 60; c++) begin
      s0_data = 8'h60 + 8'(k); s1_data = 8'(k);
      s0_valid = 1; s1_valid = 1; s0_sof = (k == 0); s1_sof = (k == 0);
      @(negedge clk);
      if (s0_ready && s1_ready) begin
        hs++; k++;
      end
      tick(1);
    end
    @(negedge clk);
    check("t3_ready_low", {s0_ready, s1_ready}, 2'b00);
    tick(1);
    check("t3_issued", hs, FD);
    idle();
    m_ready = 1;
    wait_beats(FD, 60);
    tick(5);
    check("t3_beats", out_q.size(), FD);
    for (int i = 0; i < FD && i < out_q.size(); i++) begin
      check($sformatf("t3_data[%0d]", i), out_q[i].d, merge(8'h60 + 8'(i), 8'(i)));
      check($sformatf("t3_sof[%0d]", i), out_q[i].sof, (i == 0));
    end

    // Misalignment after 12 pairs in flight.
    do_reset();
    out_q.delete();
    for (int i = 0; i < 12; i++) put_pair(8'h20 + 8'(i), 8'h10 + 8'(i), i == 0, 1'b0, hc);
    s0_data = 8'hEE; s1_data = 8'hEF; s0_sof = 0; s1_sof = 0; s0_eol = 1; s1_eol = 0;
    @(negedge clk);
    check("t4_no_issue", {s0_ready, s1_ready}, 2'b00);
    check("t4_err_pre", sync_err, 0);
    tick(1);
    check("t4_sync_err", sync_err, 1);
    @(negedge clk);
    check("t4_sync_drop", {s0_ready, s1_ready}, 2'b11);
    tick(1);
    idle();
    check("t4_err_one_cycle", sync_err, 0);
    wait_beats(12, 60);
    tick(5);
    check("t4_beats", out_q.size(), 12);
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      check($sformatf("t4_data[%0d]", i), out_q[i].d, merge(8'h20 + 8'(i), 8'h10 + 8'(i)));
    end
    check("t4_frame_cnt", frame_cnt, 1);

`ifdef HDR_SCHED_BYPASS_EN
    do_reset();
    out_q.delete();
    cfg_bypass = 1;
    put_pair(8'hAB, 8'h01, 1'b1, 1'b0, hc);
    cfg_bypass = 0;
    idle();
    wait_beats(1, 40);
    tick(5);
    check("t6_beats", out_q.size(), 1);
    if (out_q.size() >= 1) begin
      check("t6_bypass_data", out_q[0].d, 8'hAB);
      check("t6_bypass_latency", out_q[0].cyc - hc, PL + 1);
      check("t6_bypass_sof", out_q[0].sof, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
